fixed_round_pipe: RTL and testbench
===================================

Name: fixed_round_pipe

Overview:
- Pipelined, parametrised fixed-point requantiser for the fixed-point datapath, placed after multipliers and accumulators.
- Takes a signed wide product/accumulator word and drops DROPW fraction bits and GUARDW integer guard bits.
- Rounding mode is selectable per beat; overflow saturates.
- valid/ready handshake on both sides, 2-cycle latency, full throughput; a saturating event counter supports debug.

Parameters:
- INTW, 10: integer bits kept in the output, sign bit included.
- RATW, 10: fraction bits kept in the output.
- DROPW, 10: low fraction bits discarded. Must be 1..32.
- GUARDW, 2: extra input integer MSBs removed by saturation. May be 0.
- CNTW, 16: width of the saturation event counter.
- LFSR_SEED, 32'hACE1_2468: reset seed of the stochastic LFSR. Must be non-zero. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  GUARDW+INTW+RATW+DROPW  signed two's-complement input. Value = in_data / 2^(RATW+DROPW).
- in_mode  in  2  rounding mode, captured with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  INTW+RATW  signed result. Value = out_data / 2^RATW.
- out_sat  out  1  this beat was clamped.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  CNTW  number of saturated beats delivered, saturating at all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0): s1/s2 valid=0, out_valid=0, out_data=0, out_sat=0, sat_count=0, LFSR=LFSR_SEED.
- Widths: IW=GUARDW+INTW+RATW+DROPW, OW=INTW+RATW.
- Stage 1 adds an increment inc to sign-extended in_data in IW+1 bits, then arithmetic-shifts right by DROPW. h=2^(DROPW-1), k = kept LSB (in_data[DROPW]). inc by mode:
  - 00 floor (truncate toward -inf): inc=0.
  - 01 round-half-up: inc=h.
  - 10 round-half-even: inc=h-1+k.
  - 11 round-half-away-from-zero: inc=h if in_data>=0, else h-1.
- Stage 2 saturation:
  - If the shifted value exceeds 2^(OW-1)-1: out_data=max positive, out_sat=1.
  - If it is below -2^(OW-1): out_data=min negative, out_sat=1.
  - Otherwise: out_data = low OW bits, out_sat=0.
- Handshake:
  - A beat transfers on valid&&ready. Each stage loads when empty or when its occupant leaves the same cycle.
  - in_ready = !s1_v || !s2_v || out_ready. Combinational from out_ready; no combinational path from in_valid.
  - Latency: accepted at edge N, out_valid at edge N+2 with no stall.
  - Throughput is 1 beat/cycle while out_ready=1.
  - out_data, out_sat, out_valid hold stable while out_valid && !out_ready.
- sat_count:
  - Increments on each out_valid && out_ready && out_sat.
  - Holds at 2^CNTW-1.
  - sat_clr wins over a simultaneous increment; result is 0.
- in_mode may change every beat; each beat uses its own captured mode.
- Reset asserted mid-stream discards in-flight beats immediately; no partial output.

Optional Feature:
- Macro ROUND_STOCHASTIC_EN.
- Defined:
  - Mode 11 becomes stochastic rounding: inc = low DROPW bits of a 32-bit Galois LFSR (taps 32,22,2,1).
  - The LFSR advances only on accepted beats in mode 11.
  - Round-half-away-from-zero is unavailable.
- Undefined: mode 11 = round-half-away-from-zero; no LFSR logic is present.

Decomposition:
- Package fixed_pkg holds:
  - round_mode_e enum: RND_FLOOR, RND_HALF_UP, RND_HALF_EVEN, RND_AWAY_OR_STOCH.
  - LFSR tap constant.
  - Width-helper functions for IW/OW.
- One natural sub-module: fixed_sat, a combinational clamp from IW+1-DROPW bits to OW bits plus a flag, reusable by accumulators.

Test Plan (defaults: IW=32, OW=20):
- mode 10, in_data=32'h0000_0200 → out_data=20'h00000. Same data in mode 01 → 20'h00001. Both out_sat=0.
- mode 10, in_data=32'h0000_0600 → 20'h00002. mode 00, same data → 20'h00001.
- in_data=32'hFFFF_FE00 → mode 00: 20'hFFFFF; mode 01: 20'h00000; mode 11 (macro off): 20'hFFFFF; mode 10: 20'h00000.
- in_data=32'h7FFF_FFFF mode 01 → 20'h7FFFF, out_sat=1. in_data=32'h8000_0000 → 20'h80000, out_sat=1. sat_count=2. Pulse sat_clr → 0. Drive 2^16+3 saturating beats → sat_count holds 16'hFFFF.
- Stream 100 random beats with out_ready toggled randomly → every output matches the model, in order, stable while stalled. Throughput = 1/cycle when out_ready=1; first result 2 cycles after accept.
- Assert rst_n=0 with 2 beats in flight → out_valid=0 immediately, sat_count=0. After release, the next beat emerges 2 cycles after accept. With ROUND_STOCHASTIC_EN: constant 32'h0000_0200 in mode 11 over 4096 beats → mean out_data within 2% of 0.5.

Source files
------------

// File: rtl/fixed_pkg.sv
// fixed_pkg: rounding-mode type, stochastic LFSR taps and width helpers
// shared by the fixed-point requantiser and its saturation stage.
package fixed_pkg;
    typedef enum logic [1:0] {
        RND_FLOOR         = 2'd0,
        RND_HALF_UP       = 2'd1,
        RND_HALF_EVEN     = 2'd2,
        RND_AWAY_OR_STOCH = 2'd3
    } round_mode_e;

    // Galois form of the x^32 + x^22 + x^2 + x + 1 polynomial
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic int in_width(input int guardw, input int intw, input int ratw, input int dropw);
        return guardw + intw + ratw + dropw;
    endfunction

    function automatic int out_width(input int intw, input int ratw);
        return intw + ratw;
    endfunction
endpackage

// File: rtl/fixed_sat.sv
// fixed_sat: combinational clamp of a signed IN_W-bit value to OW bits with an overflow flag.
module fixed_sat #(
    parameter int IN_W = 23,
    parameter int OW   = 20
) (
    input  logic [IN_W-1:0] din,
    output logic [OW-1:0]   dout,
    output logic            sat
);
    logic [IN_W-OW:0] hi;

    // the value fits only when every bit from the output sign upward agrees
    always_comb begin
        hi   = din[IN_W-1:OW-1];
        sat  = !(&hi || ~|hi);
        dout = !sat ? din[OW-1:0] : din[IN_W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
endmodule

// File: rtl/fixed_round_pipe.sv
// fixed_round_pipe: 2-stage signed requantiser (round, shift, saturate) with valid/ready.
// Define ROUND_STOCHASTIC_EN to turn mode 11 into LFSR-driven stochastic rounding.
module fixed_round_pipe
    import fixed_pkg::*;
#(
    parameter int          INTW      = 10,
    parameter int          RATW      = 10,
    parameter int          DROPW     = 10,
    parameter int          GUARDW    = 2,
    parameter int          CNTW      = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [in_width(GUARDW, INTW, RATW, DROPW)-1:0] in_data,
    input  logic [1:0]                                    in_mode,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [out_width(INTW, RATW)-1:0]              out_data,
    output logic                                          out_sat,
    input  logic                                          sat_clr,
    output logic [CNTW-1:0]                               sat_count
);
    localparam int IW = in_width(GUARDW, INTW, RATW, DROPW);
    localparam int OW = out_width(INTW, RATW);
    localparam int SW = IW + 1 - DROPW;
    localparam logic [IW:0] H = {{IW{1'b0}}, 1'b1} << (DROPW - 1);

    if (DROPW < 1 || DROPW > 32 || LFSR_SEED == 32'd0) begin : g_bad_cfg
        $error("fixed_round_pipe: DROPW must be 1..32 and LFSR_SEED non-zero");
    end

    round_mode_e     mode;
    logic            s1_v, s2_v, s2_en, sat_flag;
    logic [IW:0]     inc, sum, odd_inc;
    logic [SW-1:0]   s1_d, s1_q;
    logic [OW-1:0]   sat_data;

`ifdef ROUND_STOCHASTIC_EN
    logic [31:0] lfsr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= LFSR_SEED;
        else if (in_valid && in_ready && mode == RND_AWAY_OR_STOCH) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
    assign odd_inc = {{(IW+1-DROPW){1'b0}}, lfsr[DROPW-1:0]};
`else
    assign odd_inc = in_data[IW-1] ? H - 1'b1 : H;
`endif

    always_comb begin
        mode = round_mode_e'(in_mode);
        inc  = mode == RND_FLOOR ? '0 :
               mode == RND_HALF_UP ? H :
               mode == RND_HALF_EVEN ? H - 1'b1 + {{IW{1'b0}}, in_data[DROPW]} : odd_inc;
        sum  = {in_data[IW-1], in_data} + inc;
        s1_d = SW'($signed(sum) >>> DROPW);
    end

    // a stage refills whenever it is empty or its occupant moves on this cycle
    assign s2_en     = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_en;
    assign out_valid = s2_v;

    fixed_sat #(.IN_W(SW), .OW(OW)) u_sat (
        .din  (s1_q),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_q     <= '0;
            s2_v     <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
                s1_q <= s1_d;
            end
            if (s2_en) begin
                s2_v     <= s1_v;
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sat_count <= '0;
        else if (sat_clr) sat_count <= '0;
        else if (out_valid && out_ready && out_sat && !(&sat_count)) sat_count <= sat_count + 1'b1;
endmodule

// File: tb/tb_fixed_round_pipe.sv
// tb_fixed_round_pipe: directed and streamed checks of the requantiser at default widths (IW=32, OW=20).
module tb_fixed_round_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sat_clr = 1'b0;
    logic        in_ready, out_valid, out_sat;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic [19:0] out_data;
    logic [15:0] sat_count;
    int          tests = 0, fails = 0, last_lat = 0;

    always #5 clk = ~clk;

    fixed_round_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: {sat, data} from exact integer rounding of value/1024, then clamp to 20 bits
    function automatic logic [20:0] model(input logic [31:0] d, input logic [1:0] m);
        longint v, q, r;
        v = longint'($signed(d));
        q = v >>> 10;
        case (m)
            2'd1: q = (v + 512) >>> 10;
            2'd2: begin
                r = v - q * 1024;
                if (r > 512 || (r == 512 && q[0])) q = q + 1;
            end
            2'd3: q = v < 0 ? -((-v + 512) >>> 10) : (v + 512) >>> 10;
            default: ;
        endcase
        if (q > 524287) return {1'b1, 20'h7FFFF};
        if (q < -524288) return {1'b1, 20'h80000};
        return {1'b0, q[19:0]};
    endfunction

    task automatic run(input string tag, input logic [31:0] d, input logic [1:0] m,
                       input logic [19:0] eq, input logic es);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_mode = m; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(eq));
        chk({tag, "_sat"}, 32'(out_sat), 32'(es));
        last_lat = lat;
    endtask

    initial begin
        logic [31:0] tp_d [5];
        logic [1:0]  tp_m [5];
        logic [20:0] sb [$];
        logic [20:0] held, exp;
        logic        acc, del, held_v;
        logic [31:0] r;
        int          issued, got, cyc;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("even_0200", 32'h0000_0200, 2'd2, 20'h00000, 1'b0);
        chk("latency", 32'(last_lat), 32'd1);
        run("up_0200", 32'h0000_0200, 2'd1, 20'h00001, 1'b0);
        run("even_0600", 32'h0000_0600, 2'd2, 20'h00002, 1'b0);
        run("floor_0600", 32'h0000_0600, 2'd0, 20'h00001, 1'b0);
        run("floor_neg", 32'hFFFF_FE00, 2'd0, 20'hFFFFF, 1'b0);
        run("up_neg", 32'hFFFF_FE00, 2'd1, 20'h00000, 1'b0);
`ifndef ROUND_STOCHASTIC_EN
        run("away_neg", 32'hFFFF_FE00, 2'd3, 20'hFFFFF, 1'b0);
        run("away_pos", 32'h0000_0600, 2'd3, 20'h00002, 1'b0);
`endif
        run("even_neg", 32'hFFFF_FE00, 2'd2, 20'h00000, 1'b0);
        run("sat_pos", 32'h7FFF_FFFF, 2'd1, 20'h7FFFF, 1'b1);
        run("sat_neg", 32'h8000_0000, 2'd1, 20'h80000, 1'b1);
        @(negedge clk);
        chk("sat_count_2", 32'(sat_count), 32'd2);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("sat_clr", 32'(sat_count), 32'd0);

        // long saturating stream pins the counter at all-ones
        in_valid = 1'b1; in_data = 32'h7FFF_FFFF; in_mode = 2'd1; out_ready = 1'b1;
        repeat (65545) @(negedge clk);
        chk("sat_count_hold", 32'(sat_count), 32'h0000_FFFF);
        sat_clr = 1'b1;
        @(negedge clk);
        chk("clr_wins", 32'(sat_count), 32'd0);
        sat_clr = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_count_drain", 32'(sat_count), 32'd2);

        // back-to-back beats: one result per cycle two cycles after each accept
        tp_d = '{32'h0000_1234, 32'hFFFF_F5FF, 32'h0001_0600, 32'h0000_0A00, 32'hFFAB_CDEF};
        tp_m = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk("tput_valid", 32'(out_valid), j >= 2 ? 32'd1 : 32'd0);
            if (j >= 2) chk("tput_data", 32'({out_sat, out_data}), 32'(model(tp_d[j-2], tp_m[j-2])));
            if (j < 5) begin
                in_valid = 1'b1; in_data = tp_d[j]; in_mode = tp_m[j];
            end else in_valid = 1'b0;
        end

        // random stream with random backpressure against a scoreboard
        issued = 0; got = 0; cyc = 0; acc = 1'b0; held_v = 1'b0; held = '0;
        while ((issued < 100 || got < 100) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (held_v) chk("stall_stable", 32'({out_valid, out_sat, out_data}), 32'({1'b1, held}));
            out_ready = 1'($urandom_range(0, 1));
            if (acc) in_valid = 1'b0;
            if (!in_valid && issued < 100) begin
                r = $urandom;
                in_valid = 1'b1;
                in_data = r[27] ? r : {{6{r[25]}}, r[25:0]};
`ifdef ROUND_STOCHASTIC_EN
                in_mode = 2'($urandom_range(0, 2));
`else
                in_mode = 2'($urandom_range(0, 3));
`endif
                issued++;
            end
            #1;
            acc = in_valid && in_ready;
            if (acc) sb.push_back(model(in_data, in_mode));
            del = out_valid && out_ready;
            if (del) begin
                exp = sb.size() > 0 ? sb.pop_front() : 21'h1F_FFFF;
                chk("stream", 32'({out_sat, out_data}), 32'(exp));
                got++;
            end
            held_v = out_valid && !out_ready;
            held = {out_sat, out_data};
        end
        chk("stream_count", 32'(got), 32'd100);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // fill both stages under backpressure, then reset mid-flight
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7FFF_FFFF; in_mode = 2'd1;
        @(negedge clk);
        in_data = 32'h8000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sat_count", 32'(sat_count), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 32'h0000_0600, 2'd0, 20'h00001, 1'b0);
        chk("after_rst_latency", 32'(last_lat), 32'd1);

`ifdef ROUND_STOCHASTIC_EN
        begin
            int sum, n;
            sum = 0; n = 0; issued = 0; cyc = 0;
            out_ready = 1'b1; in_data = 32'h0000_0200; in_mode = 2'd3;
            while (n < 4096 && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                if (out_valid) begin
                    sum += int'(out_data);
                    n++;
                end
                in_valid = issued < 4096;
                if (issued < 4096) issued++;
            end
            in_valid = 1'b0;
            chk("stoch_count", 32'(n), 32'd4096);
            chk("stoch_mean", 32'(sum >= 1966 && sum <= 2130), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
